fir_interp_tx: RTL and testbench

- Transmit-side polyphase interpolating FIR (upsample by L, pulse-shaping low-pass) for the DSP sample path.
- Accepts 8-bit signed samples on a valid/ready input and emits L filtered 16-bit outputs per input sample on a valid/ready output.
- Computation is time-multiplexed through a single multiply-accumulate unit, one tap per cycle.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_mac.sv | 39 +++
 rtl/fir_interp_tx.sv | 123 ++++++++++++
 tb/tb_fir_interp_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, coefficient table, FSM encoding and output saturation
// for the polyphase interpolating FIR.
package fir_pkg;

  localparam int DEF_DW   = 8;
  localparam int DEF_CW   = 8;
  localparam int DEF_OW   = 16;
  localparam int DEF_TAPS = 8;
  localparam int DEF_L    = 2;
  localparam int DEF_M    = DEF_TAPS / DEF_L;

  // One guard bit beyond the worst-case sum of M full-scale products
  localparam int ACC_W = DEF_DW + DEF_CW + $clog2(DEF_M) + 1;

  // Pulse-shaping prototype; branch p uses taps p, p+L, p+2L, ...
  localparam logic signed [DEF_CW-1:0] COEF [DEF_TAPS] =
    '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd4, 8'sd3, 8'sd2, 8'sd1};

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DEF_OW-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DEF_OW-1)));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  function automatic logic signed [DEF_OW-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DEF_OW-1:0];
    if (v < SAT_MIN) return SAT_MIN[DEF_OW-1:0];
    return v[DEF_OW-1:0];
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Single signed multiply-accumulate with synchronous clear; exposes the
// saturated value of the running sum including the current product.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW,
  parameter int OW = DEF_OW,
  parameter int AW = ACC_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] x,
  input  logic signed [CW-1:0] h,
  output logic signed [OW-1:0] sat
);

  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    acc_reg;

  assign prod     = x * h;
  assign prod_ext = {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
  assign sum      = acc_reg + prod_ext;
  assign sat      = saturate(sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc_reg <= '0;
    else if (clr)
      acc_reg <= '0;
    else if (en)
      acc_reg <= sum;
  end

endmodule

// File: rtl/fir_interp_tx.sv
// Polyphase interpolate-by-L FIR: one input sample yields L outputs, each
// built over M cycles through one shared MAC.
module fir_interp_tx
  import fir_pkg::*;
#(
  parameter int TAPS = DEF_TAPS,
  parameter int L    = DEF_L,
  parameter int DW   = DEF_DW,
  parameter int CW   = DEF_CW,
  parameter int OW   = DEF_OW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data
);

  localparam int M  = TAPS / L;
  localparam int AW = DW + CW + $clog2(M) + 1;
  localparam int KW = (M > 1) ? $clog2(M) : 1;
  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_t state_reg, state_next;

  logic [KW-1:0]         k_reg;
  logic [PW-1:0]         phase_reg;
  logic signed [DW-1:0]  x_reg [M];
  logic                  out_valid_reg;
  logic signed [OW-1:0]  out_data_reg;

  logic                  accept, handshake, last_tap, last_phase;
  logic                  mac_clr, mac_en;
  logic [TW-1:0]         tap_idx;
  logic signed [DW-1:0]  mac_x;
  logic signed [CW-1:0]  mac_h;
  logic signed [OW-1:0]  mac_sat;

  // in_ready must drop the instant reset rises, not a clock later
  assign in_ready   = (state_reg == IDLE) && !reset;
  assign accept     = in_valid && in_ready;
  assign handshake  = (state_reg == OUT) && out_valid_reg && out_ready;
  assign last_tap   = (k_reg == KW'(M - 1));
  assign last_phase = (phase_reg == PW'(L - 1));
  assign mac_clr    = accept || (handshake && !last_phase);
  assign mac_en     = (state_reg == MAC);
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;

  always_comb begin
    tap_idx = TW'(k_reg) * TW'(L) + TW'(phase_reg);
    mac_x   = x_reg[k_reg];
    mac_h   = COEF[tap_idx];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = MAC;
      MAC:     if (last_tap) state_next = OUT;
      OUT:     if (handshake) state_next = last_phase ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_reg         <= '0;
      phase_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      for (int i = 0; i < M; i++) x_reg[i] <= '0;
    end else begin
      if (accept) begin
        x_reg[0] <= in_data;
        for (int i = 1; i < M; i++) x_reg[i] <= x_reg[i-1];
        phase_reg <= '0;
        k_reg     <= '0;
      end
      if (mac_en) begin
        k_reg <= last_tap ? '0 : k_reg + 1'b1;
        if (last_tap) begin
          out_data_reg  <= mac_sat;
          out_valid_reg <= 1'b1;
        end
      end
      if (handshake) begin
        out_valid_reg <= 1'b0;
        if (!last_phase) begin
          phase_reg <= phase_reg + 1'b1;
          k_reg     <= '0;
        end
      end
    end
  end

  fir_mac #(
    .DW (DW),
    .CW (CW),
    .OW (OW),
    .AW (AW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .x     (mac_x),
    .h     (mac_h),
    .sat   (mac_sat)
  );

endmodule

// File: tb/tb_fir_interp_tx.sv
// Randomized and directed bench for fir_interp_tx against a convolution
// model of the upsampled pulse-shaping filter.
module tb_fir_interp_tx;

  localparam int L_TB = 2;
  localparam int M_TB = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;

  int total = 0;
  int bad   = 0;
  int hist[$];
  int got_q[$];
  int h_tb [8] = '{1, 2, 3, 4, 4, 3, 2, 1};

  fir_interp_tx dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Phase p of the newest sample: sum of x[n-k]*h[k*L+p], zero history beyond what was sent
  function automatic int ref_out(input int p);
    int acc = 0;
    for (int k = 0; k < M_TB; k++)
      if (k < hist.size()) acc += hist[k] * h_tb[k*L_TB + p];
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    hist.delete();
    got_q.delete();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
  endtask

  task automatic push(input int s, input bit stall, input bit noise);
    int exp_v [L_TB];
    int cyc;
    int hold;
    int d;
    hist.push_front(s);
    if (hist.size() > M_TB) void'(hist.pop_back());
    for (int p = 0; p < L_TB; p++) exp_v[p] = ref_out(p);
    out_ready = !stall;
    in_valid  = 1'b1;
    in_data   = 8'(s);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("accept_ready", in_ready, 1);
    @(negedge clk);
    cyc = 0;
    for (int p = 0; p < L_TB; p++) begin
      in_valid = noise;
      if (noise) in_data = 8'($urandom);
      while (!out_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (noise) in_data = 8'($urandom);
      end
      check($sformatf("latency s=%0d p=%0d", s, p), cyc, M_TB);
      check($sformatf("data s=%0d p=%0d", s, p), out_data, exp_v[p]);
      check("busy_in_ready", in_ready, 0);
      got_q.push_back(int'(out_data));
      d = int'(out_data);
      if (stall) begin
        hold = $urandom_range(1, 5);
        repeat (hold) begin
          @(negedge clk);
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, d);
          check("hold_in_ready", in_ready, 0);
        end
      end
      if (p == L_TB - 1) in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = !stall;
      cyc = 0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int exp_seq[$]);
    check({tag, "_count"}, got_q.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < got_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got_q[i], exp_seq[i]);
    got_q.delete();
  endtask

  initial begin
    int cyc;
    do_reset();

    // impulse
    push(1, 0, 0); push(0, 0, 0); push(0, 0, 0); push(0, 0, 0); push(0, 0, 0);
    check_seq("impulse", '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0});

    // step
    do_reset();
    for (int i = 0; i < 4; i++) push(10, 0, 0);
    check_seq("step", '{10, 20, 40, 60, 80, 90, 100, 100});

    // negative impulse
    do_reset();
    push(-128, 0, 0); push(0, 0, 0); push(0, 0, 0); push(0, 0, 0);
    check_seq("neg", '{-128, -256, -384, -512, -512, -384, -256, -128});

    // reset two cycles into MAC
    do_reset();
    in_valid = 1'b1; in_data = 8'sd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midmac_out_valid", out_valid, 0);
    check("midmac_out_data", out_data, 0);
    check("midmac_in_ready", in_ready, 0);
    do_reset();
    push(1, 0, 0);
    check_seq("after_midmac", '{1, 2});

    // reset while an output is stalled in OUT
    do_reset();
    in_valid = 1'b1; in_data = 8'sd7;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("midout_latency", cyc, M_TB);
    check("midout_data", out_data, 7);
    reset = 1'b1;
    #1;
    check("midout_out_valid", out_valid, 0);
    check("midout_out_data", out_data, 0);
    check("midout_in_ready", in_ready, 0);
    do_reset();
    push(1, 0, 0);
    check_seq("after_midout", '{1, 2});

    // random samples, random backpressure, in_valid noise while busy
    do_reset();
    for (int i = 0; i < 30; i++)
      push($signed(8'($urandom)), 1'($urandom), 1'($urandom));
    check("random_outputs", got_q.size(), 30 * L_TB);
    @(negedge clk);
    check("final_idle_out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
